// File: rtl/wb_buffered_unit_pkg.sv
// Shared definitions for the write-back stage: datapath widths, ISA opcodes,
// register-file write-mode encodings and the opcode-to-write decoder.
package wb_buffered_unit_pkg;

   localparam int WIDTH        = 32;
   localparam int REG_ADDR_LEN = 5;

   localparam logic [5:0] OP_R_TYPE = 6'h00;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_I_TYPE = 6'h08;
   localparam logic [5:0] OP_JALR   = 6'h09;
   localparam logic [5:0] OP_LH     = 6'h21;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_SW     = 6'h2B;
   localparam logic [5:0] OP_LD     = 6'h37;
   localparam logic [5:0] OP_HALT   = 6'h3F;

   localparam logic [1:0] WMODE_WORD = 2'd0;
   localparam logic [1:0] WMODE_HALF = 2'd1;
   localparam logic [1:0] WMODE_BYTE = 2'd2;

   typedef struct packed {
      logic       en;
      logic [1:0] mode;
   } wb_dec_t;

   // Which opcodes write the register file, and at what width.
   function automatic wb_dec_t wb_decode(input logic [5:0] op);
      wb_dec_t d;
      d.en   = 1'b0;
      d.mode = WMODE_WORD;
      case (op)
         OP_LW, OP_R_TYPE, OP_I_TYPE, OP_JAL, OP_JALR: begin
            d.en   = 1'b1;
            d.mode = WMODE_WORD;
         end
         OP_LH, OP_LD: begin
            d.en   = 1'b1;
            d.mode = WMODE_HALF;
         end
         default: begin
            d.en   = 1'b0;
            d.mode = WMODE_WORD;
         end
      endcase
      return d;
   endfunction

endpackage

// File: rtl/wb_buffered_unit_fifo.sv
// wb_write_fifo: DEPTH-entry register-write queue with wrap-bit pointers.
// Optional youngest-match forwarding search under `WB_FWD_EN.
module wb_write_fifo
   import wb_buffered_unit_pkg::*;
#(
   parameter int AW    = 5,
   parameter int DW    = 32,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_push,
   input  logic [AW-1:0] i_addr,
   input  logic [DW-1:0] i_data,
   input  logic [1:0]    i_mode,
   input  logic          i_pop,
   output logic          o_full,
   output logic          o_empty,
   output logic [AW-1:0] o_addr,
   output logic [DW-1:0] o_data,
   output logic [1:0]    o_mode
`ifdef WB_FWD_EN
   ,
   input  logic [AW-1:0] i_fwd_addr,
   output logic          o_fwd_hit,
   output logic [DW-1:0] o_fwd_data
`endif
);

   localparam int PW = $clog2(DEPTH);

   logic [PW:0]   r_wptr;
   logic [PW:0]   r_rptr;
   logic [AW-1:0] r_addr [DEPTH];
   logic [DW-1:0] r_data [DEPTH];
   logic [1:0]    r_mode [DEPTH];
   logic [AW-1:0] r_last_addr;
   logic [DW-1:0] r_last_data;
   logic [1:0]    r_last_mode;

   logic          w_push;
   logic          w_pop;
   logic [PW-1:0] w_widx;
   logic [PW-1:0] w_ridx;

   assign w_widx  = r_wptr[PW-1:0];
   assign w_ridx  = r_rptr[PW-1:0];
   assign o_empty = (r_wptr == r_rptr);
   assign o_full  = (r_wptr[PW] != r_rptr[PW]) && (w_widx == w_ridx);
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;

   // Head entry while occupied; otherwise the last entry that left.
   assign o_addr = o_empty ? r_last_addr : r_addr[w_ridx];
   assign o_data = o_empty ? r_last_data : r_data[w_ridx];
   assign o_mode = o_empty ? r_last_mode : r_mode[w_ridx];

   // Pointer advance; the wrap bit separates full from empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

   // Entry storage; contents are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr[w_widx] <= i_addr;
         r_data[w_widx] <= i_data;
         r_mode[w_widx] <= i_mode;
      end
   end

   // Remember the popped entry so outputs hold it once the queue empties.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_addr <= '0;
         r_last_data <= '0;
         r_last_mode <= WMODE_WORD;
      end else if (w_pop) begin
         r_last_addr <= r_addr[w_ridx];
         r_last_data <= r_data[w_ridx];
         r_last_mode <= r_mode[w_ridx];
      end
   end

`ifdef WB_FWD_EN
   logic [PW:0]   w_count;
   logic [PW-1:0] w_fidx;

   assign w_count = r_wptr - r_rptr;

   // Walk oldest to youngest so the last match found is the youngest.
   always_comb begin
      o_fwd_hit  = 1'b0;
      o_fwd_data = '0;
      w_fidx     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_fidx = w_ridx + PW'(i);
         if (((PW+1)'(i) < w_count) && (i_fwd_addr != '0) &&
             (r_addr[w_fidx] == i_fwd_addr)) begin
            o_fwd_hit  = 1'b1;
            o_fwd_data = r_data[w_fidx];
         end
      end
   end
`endif

endmodule

// File: rtl/wb_buffered_unit.sv
// wb_buffered_unit: write-back stage with buffered register-file writes and Halt.
// Define WB_FWD_EN to add the fwd_addr/fwd_hit/fwd_data lookup port.
module wb_buffered_unit
   import wb_buffered_unit_pkg::*;
#(
   parameter int WIDTH        = wb_buffered_unit_pkg::WIDTH,
   parameter int REG_ADDR_LEN = wb_buffered_unit_pkg::REG_ADDR_LEN,
   parameter int DEPTH        = 4,
   parameter int COUNT_W      = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [WIDTH-1:0]        IR_in,
   input  logic [WIDTH-3:0]        PC_in,
   input  logic [WIDTH-1:0]        Z_in,
   output logic [REG_ADDR_LEN-1:0] Addr,
   output logic [WIDTH-1:0]        Data,
   output logic [1:0]              w_mode,
   output logic                    wr_en,
   input  logic                    rf_ready,
   output logic                    Halt,
   output logic [COUNT_W-1:0]      retire_cnt
`ifdef WB_FWD_EN
   ,
   input  logic [REG_ADDR_LEN-1:0] fwd_addr,
   output logic                    fwd_hit,
   output logic [WIDTH-1:0]        fwd_data
`endif
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t                  r_state;
   logic                    r_halt;
   logic [COUNT_W-1:0]      r_retire;

   logic                    w_transfer;
   logic                    w_push;
   logic                    w_full;
   logic                    w_empty;
   logic [5:0]              w_op;
   logic [REG_ADDR_LEN-1:0] w_rd;
   wb_dec_t                 w_dec;
   logic                    w_unused;

   assign w_op       = IR_in[31:26];
   assign w_rd       = IR_in[21 +: REG_ADDR_LEN];
   assign w_dec      = wb_decode(w_op);
   assign in_ready   = (r_state == RUN) & ~w_full;
   assign w_transfer = in_valid & in_ready;
   assign w_push     = w_transfer & w_dec.en & (w_rd != '0);
   assign wr_en      = ~w_empty;
   assign Halt       = r_halt;
   assign retire_cnt = r_retire;
   assign w_unused   = ^{PC_in, IR_in[20:0]};

   wb_write_fifo #(
      .AW    (REG_ADDR_LEN),
      .DW    (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_push     (w_push),
      .i_addr     (w_rd),
      .i_data     (Z_in),
      .i_mode     (w_dec.mode),
      .i_pop      (rf_ready),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_addr     (Addr),
      .o_data     (Data),
      .o_mode     (w_mode)
`ifdef WB_FWD_EN
      ,
      .i_fwd_addr (fwd_addr),
      .o_fwd_hit  (fwd_hit),
      .o_fwd_data (fwd_data)
`endif
   );

   // Halt sequencing: stop accepting on HALT, halt once older writes drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RUN;
         r_halt  <= 1'b0;
      end else begin
         case (r_state)
            RUN: begin
               if (w_transfer && (w_op == OP_HALT)) r_state <= DRAIN;
            end
            DRAIN: begin
               if (w_empty) begin
                  r_state <= HALTED;
                  r_halt  <= 1'b1;
               end
            end
            default: begin
               r_state <= HALTED;
               r_halt  <= 1'b1;
            end
         endcase
      end
   end

   // Count every accepted instruction, writing or not.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_retire <= '0;
      else if (w_transfer) r_retire <= r_retire + 1'b1;
   end

endmodule

// File: tb/tb_wb_buffered_unit.sv
// Randomized self-checking bench for wb_buffered_unit.
// Reference model: a queue of pending writes plus a halt phase.
module tb_wb_buffered_unit;
   import wb_buffered_unit_pkg::*;

   localparam int DEPTH = 4;
   localparam int CW    = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] IR_in;
   logic [29:0] PC_in;
   logic [31:0] Z_in;
   logic [4:0]  Addr;
   logic [31:0] Data;
   logic [1:0]  w_mode;
   logic        wr_en;
   logic        rf_ready;
   logic        Halt;
   logic [CW-1:0] retire_cnt;
`ifdef WB_FWD_EN
   logic [4:0]  fwd_addr;
   logic        fwd_hit;
   logic [31:0] fwd_data;
`endif

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
      logic [1:0]  m;
   } ent_t;

   ent_t        q[$];
   ent_t        last;
   int          m_phase;
   int unsigned m_cnt;

   always #5 clk = ~clk;

   wb_buffered_unit #(
      .DEPTH   (DEPTH),
      .COUNT_W (CW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .IR_in      (IR_in),
      .PC_in      (PC_in),
      .Z_in       (Z_in),
      .Addr       (Addr),
      .Data       (Data),
      .w_mode     (w_mode),
      .wr_en      (wr_en),
      .rf_ready   (rf_ready),
      .Halt       (Halt),
      .retire_cnt (retire_cnt)
`ifdef WB_FWD_EN
      ,
      .fwd_addr   (fwd_addr),
      .fwd_hit    (fwd_hit),
      .fwd_data   (fwd_data)
`endif
   );

   function automatic logic [31:0] mk_ir(input logic [5:0] op, input logic [4:0] rd);
      logic [20:0] low;
      low = 21'($urandom);
      return {op, rd, low};
   endfunction

   task automatic model_write(input logic [31:0] ir, output bit en, output logic [1:0] m);
      en = 1'b0;
      m  = 2'd0;
      case (ir[31:26])
         OP_LW, OP_R_TYPE, OP_I_TYPE, OP_JAL, OP_JALR: begin en = 1'b1; m = 2'd0; end
         OP_LH, OP_LD: begin en = 1'b1; m = 2'd1; end
         default: en = 1'b0;
      endcase
      if (ir[25:21] == 5'd0) en = 1'b0;
   endtask

   task automatic cyc(input bit v, input logic [31:0] ir, input logic [31:0] z, input bit rfr);
      bit         xfer;
      bit         en;
      logic [1:0] m;
      ent_t       e;
      in_valid = v;
      IR_in    = ir;
      Z_in     = z;
      rf_ready = rfr;
      PC_in    = 30'($urandom);
      xfer = v && (m_phase == 0) && (q.size() < DEPTH);
      @(posedge clk);
      if (m_phase == 1 && q.size() == 0) m_phase = 2;
      if (rfr && q.size() > 0) last = q.pop_front();
      if (xfer) begin
         m_cnt++;
         model_write(ir, en, m);
         if (en) begin
            e.a = ir[25:21];
            e.d = z;
            e.m = m;
            q.push_back(e);
         end
         if (ir[31:26] == OP_HALT) m_phase = 1;
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      rf_ready = 1'b0;
      IR_in    = '0;
      Z_in     = '0;
      PC_in    = '0;
`ifdef WB_FWD_EN
      fwd_addr = '0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      q.delete();
      last    = '{a: 5'd0, d: 32'd0, m: 2'd0};
      m_phase = 0;
      m_cnt   = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({wr_en, Addr, Data, w_mode, Halt, retire_cnt, in_ready} !==
          {1'b0, 5'd0, 32'd0, 2'd0, 1'b0, 16'd0, 1'b1}) begin
         failures++;
         $display("FAIL reset_state: got wr=%b a=%0d d=%h m=%0d h=%b cnt=%0d rdy=%b, need 0 0 0 0 0 0 1",
                  wr_en, Addr, Data, w_mode, Halt, retire_cnt, in_ready);
      end
   endtask

   task automatic test_lw();
      do_reset();
      cyc(1, mk_ir(OP_LW, 5'd3), 32'hDEADBEEF, 1);
      checks++;
      if ({wr_en, Addr, Data, w_mode} !== {1'b1, 5'd3, 32'hDEADBEEF, 2'd0}) begin
         failures++;
         $display("FAIL lw_write: got wr=%b a=%0d d=%h m=%0d, need 1 3 deadbeef 0",
                  wr_en, Addr, Data, w_mode);
      end
      cyc(0, '0, '0, 1);
      checks++;
      if ({wr_en, Addr, Data} !== {1'b0, 5'd3, 32'hDEADBEEF}) begin
         failures++;
         $display("FAIL lw_hold_after_pop: got wr=%b a=%0d d=%h, need 0 3 deadbeef",
                  wr_en, Addr, Data);
      end
   endtask

   task automatic test_lh_rd0();
      do_reset();
      cyc(1, mk_ir(OP_LH, 5'd7), 32'h0000_1234, 0);
      cyc(1, mk_ir(OP_R_TYPE, 5'd0), 32'h5555_5555, 0);
      checks++;
      if ({wr_en, Addr, Data, w_mode, retire_cnt} !==
          {1'b1, 5'd7, 32'h1234, 2'd1, 16'd2}) begin
         failures++;
         $display("FAIL lh_rd0: got wr=%b a=%0d d=%h m=%0d cnt=%0d, need 1 7 1234 1 2",
                  wr_en, Addr, Data, w_mode, retire_cnt);
      end
      cyc(0, '0, '0, 1);
      checks++;
      if (wr_en !== 1'b0) begin
         failures++;
         $display("FAIL rd0_no_write: got wr_en=%b, need 0", wr_en);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 4; i++)
         cyc(1, mk_ir(OP_R_TYPE, 5'(i + 1)), 32'(100 + i), 0);
      checks++;
      if ({in_ready, wr_en, retire_cnt} !== {1'b0, 1'b1, 16'd4}) begin
         failures++;
         $display("FAIL full_stall: got rdy=%b wr=%b cnt=%0d, need 0 1 4",
                  in_ready, wr_en, retire_cnt);
      end
      cyc(1, mk_ir(OP_R_TYPE, 5'd9), 32'd999, 0);
      checks++;
      if ({in_ready, retire_cnt} !== {1'b0, 16'd4}) begin
         failures++;
         $display("FAIL full_reject: got rdy=%b cnt=%0d, need 0 4", in_ready, retire_cnt);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({wr_en, Addr, Data} !== {1'b1, 5'(i + 1), 32'(100 + i)}) begin
            failures++;
            $display("FAIL drain_order[%0d]: got wr=%b a=%0d d=%0d, need 1 %0d %0d",
                     i, wr_en, Addr, Data, i + 1, 100 + i);
         end
         cyc(0, '0, '0, 1);
      end
      checks++;
      if ({wr_en, in_ready} !== 2'b01) begin
         failures++;
         $display("FAIL drain_empty: got wr=%b rdy=%b, need 0 1", wr_en, in_ready);
      end
   endtask

   task automatic test_halt_drain();
      do_reset();
      for (int i = 0; i < 3; i++)
         cyc(1, mk_ir(OP_I_TYPE, 5'(i + 10)), 32'(i), 0);
      cyc(1, mk_ir(OP_HALT, 5'd0), '0, 0);
      repeat (3) cyc(0, '0, '0, 0);
      checks++;
      if ({Halt, in_ready, wr_en} !== 3'b001) begin
         failures++;
         $display("FAIL halt_blocked: got h=%b rdy=%b wr=%b, need 0 0 1", Halt, in_ready, wr_en);
      end
      repeat (3) cyc(0, '0, '0, 1);
      checks++;
      if ({Halt, wr_en} !== 2'b00) begin
         failures++;
         $display("FAIL halt_early: got h=%b wr=%b, need 0 0", Halt, wr_en);
      end
      cyc(0, '0, '0, 1);
      checks++;
      if ({Halt, in_ready} !== 2'b10) begin
         failures++;
         $display("FAIL halt_set: got h=%b rdy=%b, need 1 0", Halt, in_ready);
      end
      cyc(1, mk_ir(OP_LW, 5'd1), 32'd7, 1);
      checks++;
      if ({Halt, wr_en, retire_cnt} !== {1'b1, 1'b0, 16'd4}) begin
         failures++;
         $display("FAIL halt_sticky: got h=%b wr=%b cnt=%0d, need 1 0 4", Halt, wr_en, retire_cnt);
      end
   endtask

   task automatic test_halt_empty();
      do_reset();
      cyc(1, mk_ir(OP_HALT, 5'd0), '0, 1);
      checks++;
      if ({Halt, in_ready} !== 2'b00) begin
         failures++;
         $display("FAIL halt_empty_drain: got h=%b rdy=%b, need 0 0", Halt, in_ready);
      end
      cyc(0, '0, '0, 1);
      checks++;
      if (Halt !== 1'b1) begin
         failures++;
         $display("FAIL halt_empty_set: got h=%b, need 1", Halt);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      cyc(1, mk_ir(OP_LW, 5'd4), 32'hAAAA, 0);
      cyc(1, mk_ir(OP_LD, 5'd5), 32'hBBBB, 0);
      cyc(1, mk_ir(OP_HALT, 5'd0), '0, 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({wr_en, Halt, retire_cnt, in_ready, Addr} !== {1'b0, 1'b0, 16'd0, 1'b1, 5'd0}) begin
         failures++;
         $display("FAIL reset_mid: got wr=%b h=%b cnt=%0d rdy=%b a=%0d, need 0 0 0 1 0",
                  wr_en, Halt, retire_cnt, in_ready, Addr);
      end
      do_reset();
   endtask

   task automatic test_random();
      logic [5:0]  op;
      logic [31:0] ir;
      bit          exp_rdy;
      ent_t        h;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         h = (q.size() > 0) ? q[0] : last;
         exp_rdy = (m_phase == 0) && (q.size() < DEPTH);
         checks++;
         if ({wr_en, Addr, Data, w_mode, in_ready, Halt, retire_cnt} !==
             {(q.size() > 0), h.a, h.d, h.m, exp_rdy, (m_phase == 2), CW'(m_cnt)}) begin
            failures++;
            $display("FAIL random[%0d]: got wr=%b a=%0d d=%h m=%0d rdy=%b h=%b cnt=%0d, need %b %0d %h %0d %b %b %0d",
                     n, wr_en, Addr, Data, w_mode, in_ready, Halt, retire_cnt,
                     (q.size() > 0), h.a, h.d, h.m, exp_rdy, (m_phase == 2), CW'(m_cnt));
         end
         if (m_phase == 2 && $urandom_range(0, 3) == 0) begin
            do_reset();
            continue;
         end
         if ($urandom_range(0, 59) == 0) op = OP_HALT;
         else begin
            case ($urandom_range(0, 9))
               0: op = OP_LW;
               1: op = OP_LH;
               2: op = OP_LD;
               3: op = OP_R_TYPE;
               4: op = OP_I_TYPE;
               5: op = OP_JAL;
               6: op = OP_JALR;
               7: op = OP_SW;
               8: op = OP_BEQ;
               default: op = 6'($urandom);
            endcase
         end
         ir = mk_ir(op, 5'($urandom_range(0, 7)));
         cyc($urandom_range(0, 3) != 0, ir, $urandom, $urandom_range(0, 9) < 6);
      end
   endtask

`ifdef WB_FWD_EN
   task automatic test_fwd();
      do_reset();
      cyc(1, mk_ir(OP_LW, 5'd5), 32'h11, 0);
      cyc(1, mk_ir(OP_R_TYPE, 5'd5), 32'h22, 0);
      fwd_addr = 5'd5;
      #1;
      checks++;
      if ({fwd_hit, fwd_data} !== {1'b1, 32'h22}) begin
         failures++;
         $display("FAIL fwd_youngest: got hit=%b d=%h, need 1 22", fwd_hit, fwd_data);
      end
      fwd_addr = 5'd6;
      #1;
      checks++;
      if (fwd_hit !== 1'b0) begin
         failures++;
         $display("FAIL fwd_miss: got hit=%b, need 0", fwd_hit);
      end
      fwd_addr = 5'd0;
      #1;
      checks++;
      if (fwd_hit !== 1'b0) begin
         failures++;
         $display("FAIL fwd_zero: got hit=%b, need 0", fwd_hit);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_lw();
      test_lh_rd0();
      test_back_to_back();
      test_halt_drain();
      test_halt_empty();
      test_reset_mid();
`ifdef WB_FWD_EN
      test_fwd();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
